// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: PC write enable, IF/ID stall/flush, ID/EX bubble, global freeze, debug run/step and HALT drain.
// Optional performance counters (o_cycle_cnt, o_stall_cnt) are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
  parameter int DRAIN_CYCLES = 3
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_mode_step,
  input  logic             i_step,
  input  logic             i_halt_instr,
  input  logic             i_ld_use,
  input  logic             i_branch_taken,
  input  logic             i_mem_busy,
  output logic             o_pc_we,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_bubble,
  output logic             o_halt,
  output logic             o_halted,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_stall_cnt,
`endif
  output logic [1:0]       o_state
);

  // state  | meaning
  // IDLE   | waiting for i_run, pipeline frozen
  // RUN    | fetching and executing
  // DRAIN  | HALT left ID, no fetch, waiting for it to reach WB
  // HALTED | parked until reset
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt;
  logic          adv;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    adv           = ((state == RUN) || (state == DRAIN)) && !i_mem_busy &&
                    (!i_mode_step || i_step);
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    o_pc_we       = 1'b0;
    o_ifid_stall  = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_halt        = !adv;
    o_halted      = 1'b0;
    case (state)
      IDLE: begin
        if (i_run) state_nxt = RUN;
      end
      RUN: begin
        if (adv) begin
          if (i_ld_use) begin
            o_ifid_stall  = 1'b1;
            o_idex_bubble = 1'b1;
          end else if (i_halt_instr) begin
            o_ifid_flush  = 1'b1;
            drain_cnt_nxt = DW'(DRAIN_CYCLES);
            state_nxt     = DRAIN;
          end else if (i_branch_taken) begin
            o_pc_we      = 1'b1;
            o_ifid_flush = 1'b1;
          end else begin
            o_pc_we = 1'b1;
          end
        end
      end
      DRAIN: begin
        // Terminal count reached on the adv cycle that retires HALT in WB
        if (adv) begin
          o_ifid_flush  = 1'b1;
          drain_cnt_nxt = drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) state_nxt = HALTED;
        end
      end
      HALTED: begin
        o_halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_state = state;

`ifdef PIPE_PERF_CNT_EN
  // Counters only move on adv cycles, so they hold naturally in IDLE and HALTED
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
    end else if (adv) begin
      if (o_cycle_cnt != '1) o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
      if ((state == RUN) && i_ld_use && (o_stall_cnt != '1))
        o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst, run, mode_step, step, halt_instr, ld_use, br, mem_busy;
  logic pc_we, ifid_stall, ifid_flush, idex_bubble, halt, halted;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  pipeline_ctrl dut (
    .clk(clk), .i_rst(rst), .i_run(run), .i_mode_step(mode_step), .i_step(step),
    .i_halt_instr(halt_instr), .i_ld_use(ld_use), .i_branch_taken(br), .i_mem_busy(mem_busy),
    .o_pc_we(pc_we), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_halt(halt), .o_halted(halted),
`ifdef PIPE_PERF_CNT_EN
    .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt),
`endif
    .o_state(state)
  );

  always #5 clk = ~clk;

  logic [7:0] outs;
  assign outs = {pc_we, ifid_stall, ifid_flush, idex_bubble, halt, halted, state};

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0..3, number of drain advances still owed, perf tallies
  int         m_phase = 0;
  int         m_left  = 0;
  bit         m_adv;
  logic [7:0] exp_outs;
  longint     m_cyc = 0;
  longint     m_stl = 0;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  task automatic model_comb();
    bit e_pc, e_st, e_fl, e_bb;
    e_pc = 0; e_st = 0; e_fl = 0; e_bb = 0;
    m_adv = (m_phase == 1 || m_phase == 2) && !mem_busy && (!mode_step || step);
    if (m_adv && m_phase == 1) begin
      if (ld_use)          begin e_st = 1; e_bb = 1; end
      else if (halt_instr) e_fl = 1;
      else if (br)         begin e_pc = 1; e_fl = 1; end
      else                 e_pc = 1;
    end
    if (m_adv && m_phase == 2) e_fl = 1;
    exp_outs = {e_pc, e_st, e_fl, e_bb, !m_adv, (m_phase == 3), 2'(m_phase)};
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_left = 0; m_cyc = 0; m_stl = 0;
    end else begin
      if (m_adv && m_cyc < CNT_MAX) m_cyc++;
      if (m_adv && m_phase == 1 && ld_use && m_stl < CNT_MAX) m_stl++;
      if (m_phase == 0 && run) m_phase = 1;
      else if (m_phase == 1 && m_adv && !ld_use && halt_instr) begin
        m_phase = 2; m_left = 3;
      end else if (m_phase == 2 && m_adv) begin
        m_left--;
        if (m_left == 0) m_phase = 3;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    rst = 0; run = 0; step = 0; halt_instr = 0; ld_use = 0; br = 0; mem_busy = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    mode_step = 0;
    do_reset();
    #1; model_comb();
    checks++;
    if (outs !== 8'b0000_1000 || exp_outs !== 8'b0000_1000) begin
      errors++; $display("FAIL reset_outs got %b want %b", outs, 8'b0000_1000);
    end
  endtask

  task automatic test_run_start();
    run = 1; step = 1;
    #1; model_comb();
    checks++;
    if (outs !== exp_outs) begin errors++; $display("FAIL run_idle_cycle got %b want %b", outs, exp_outs); end
    tick(); run = 0; step = 0;
    #1; model_comb();
    checks++;
    if (outs !== 8'b1000_0001) begin errors++; $display("FAIL run_entered got %b want %b", outs, 8'b1000_0001); end
  endtask

  task automatic test_ld_use();
    ld_use = 1;
    #1; model_comb();
    checks++;
    if (outs !== 8'b0101_0001) begin errors++; $display("FAIL ld_use_stall got %b want %b", outs, 8'b0101_0001); end
    tick(); ld_use = 0;
    #1; model_comb();
    checks++;
    if (outs !== exp_outs) begin errors++; $display("FAIL ld_use_release got %b want %b", outs, exp_outs); end
  endtask

  task automatic test_ld_branch();
    ld_use = 1; br = 1;
    #1; model_comb();
    checks++;
    if (outs !== 8'b0101_0001) begin errors++; $display("FAIL ld_over_branch got %b want %b", outs, 8'b0101_0001); end
    tick(); ld_use = 0;
    #1; model_comb();
    checks++;
    if (outs !== 8'b1010_0001) begin errors++; $display("FAIL branch_flush got %b want %b", outs, 8'b1010_0001); end
    tick(); br = 0;
  endtask

  task automatic test_halt_drain();
    int flush_cycles = 0;
    halt_instr = 1;
    #1; model_comb();
    checks++;
    if (outs !== 8'b0010_0001) begin errors++; $display("FAIL halt_in_id got %b want %b", outs, 8'b0010_0001); end
    tick();
    for (int i = 0; i < 3; i++) begin
      halt_instr = 1'($urandom); ld_use = 1'($urandom); br = 1'($urandom);
      #1; model_comb();
      if (pc_we == 0 && ifid_flush == 1 && state == 2'd2) flush_cycles++;
      checks++;
      if (outs !== exp_outs) begin errors++; $display("FAIL drain_cycle%0d got %b want %b", i, outs, exp_outs); end
      tick();
    end
    clear_inputs();
    checks++;
    if (flush_cycles != 3) begin errors++; $display("FAIL drain_len got %0d want %0d", flush_cycles, 3); end
    run = 1;
    #1; model_comb();
    checks++;
    if (outs !== 8'b0000_1111) begin errors++; $display("FAIL halted got %b want %b", outs, 8'b0000_1111); end
    tick(); run = 0;
    #1; model_comb();
    checks++;
    if (outs !== 8'b0000_1111) begin errors++; $display("FAIL halted_sticky got %b want %b", outs, 8'b0000_1111); end
  endtask

  task automatic test_drain_busy_reset();
    do_reset();
    run = 1; tick(); run = 0;
    halt_instr = 1; tick(); halt_instr = 0;
    tick();
    mem_busy = 1;
    for (int i = 0; i < 5; i++) begin
      #1; model_comb();
      checks++;
      if (outs !== 8'b0000_1010) begin errors++; $display("FAIL drain_busy%0d got %b want %b", i, outs, 8'b0000_1010); end
      tick();
    end
    mem_busy = 0;
    tick();
    #1; model_comb();
    checks++;
    if (outs !== 8'b0010_0010) begin errors++; $display("FAIL drain_last got %b want %b", outs, 8'b0010_0010); end
    tick();
    #1; model_comb();
    checks++;
    if (outs !== 8'b0000_1111) begin errors++; $display("FAIL drain_busy_done got %b want %b", outs, 8'b0000_1111); end
    do_reset();
    run = 1; tick(); run = 0;
    halt_instr = 1; tick(); halt_instr = 0;
    rst = 1; tick(); rst = 0;
    #1; model_comb();
    checks++;
    if (outs !== 8'b0000_1000) begin errors++; $display("FAIL reset_in_drain got %b want %b", outs, 8'b0000_1000); end
  endtask

  task automatic test_step_mode();
    int adv_seen = 0;
    do_reset();
    mode_step = 1;
    run = 1; tick(); run = 0;
    for (int i = 0; i < 10; i++) begin
      ld_use = 1'($urandom); br = 1'($urandom);
      #1; model_comb();
      checks++;
      if (outs !== 8'b0000_1001) begin errors++; $display("FAIL step_wait%0d got %b want %b", i, outs, 8'b0000_1001); end
      tick();
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      step = 1;
      #1; model_comb();
      if (!halt) adv_seen++;
      checks++;
      if (outs !== exp_outs) begin errors++; $display("FAIL step_pulse%0d got %b want %b", i, outs, exp_outs); end
      tick(); step = 0; tick();
    end
    checks++;
    if (adv_seen != 3) begin errors++; $display("FAIL step_adv_count got %0d want %0d", adv_seen, 3); end
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (cycle_cnt !== 32'd3) begin errors++; $display("FAIL step_cycle_cnt got %0d want %0d", cycle_cnt, 3); end
`endif
    mode_step = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      run        = ($urandom_range(0, 7) == 0);
      step       = 1'($urandom);
      halt_instr = ($urandom_range(0, 15) == 0);
      ld_use     = ($urandom_range(0, 3) == 0);
      br         = ($urandom_range(0, 3) == 0);
      mem_busy   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 31) == 0) mode_step = ~mode_step;
      #1; model_comb();
      checks++;
      if (outs !== exp_outs) begin errors++; $display("FAIL random%0d got %b want %b", i, outs, exp_outs); end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (cycle_cnt !== 32'(m_cyc) || stall_cnt !== 32'(m_stl)) begin
        errors++;
        $display("FAIL random_perf%0d got %0d/%0d want %0d/%0d", i, cycle_cnt, stall_cnt, m_cyc, m_stl);
      end
`endif
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    mode_step = 0;
    rst = 1;
    tick(); tick();
    test_reset();
    test_run_start();
    test_ld_use();
    test_ld_branch();
    test_halt_drain();
    test_drain_busy_reset();
    test_step_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
